regfile_8x32_sb: RTL and testbench
==================================

Name: regfile_8x32_sb

Overview:
- Eight-entry general register file with two combinational read ports, one synchronous write port, and a per-register busy scoreboard.
- Write-address decode is internal: the 3-bit write address becomes a one-hot 8-bit write strobe, which is also exported (registered) for debug LEDs.
- Sits between instruction decode (read addresses, busy marking) and writeback (write port). Provides operand data and RAW-hazard flags to the issue/stall logic.

Parameters:
- WIDTH, 32, data width of each register.
- NREG, 8, register count; fixed at 8 (3-bit addresses), present for documentation only.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- rd_addr1  input  3  read port 1 address.
- rd_data1  output  WIDTH  read port 1 data.
- hazard1  output  1  register at rd_addr1 is busy and not being written this cycle.
- rd_addr2  input  3  read port 2 address.
- rd_data2  output  WIDTH  read port 2 data.
- hazard2  output  1  as hazard1, for rd_addr2.
- wr_en  input  1  writeback strobe.
- wr_addr  input  3  writeback address.
- wr_data  input  WIDTH  writeback data.
- busy_set  input  1  mark busy_addr as having an outstanding producer.
- busy_addr  input  3  register to mark busy.
- busy  output  8  scoreboard vector; bit n = register n busy.
- wr_onehot_q  output  8  registered one-hot of the last accepted write; 0 when no write.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: on a rising clk edge with reset=1, all registers, busy and wr_onehot_q are cleared to 0. wr_en and busy_set in that cycle are ignored. After reset, every read returns 0 and hazard1/hazard2 are 0.
- Write decode: strobe[n] = wr_en & (wr_addr==n), built as a 3-to-8 decode gated by wr_en. Exactly one bit is set when wr_en=1; all bits are 0 otherwise.
- Write: on the rising edge, reg[n] <= wr_data for the set strobe bit. Latency is 1 cycle; the value is visible through the array on the next cycle.
- Read: combinational from the array, with write-through bypass. If wr_en & wr_addr==rd_addrN, then rd_dataN = wr_data in the same cycle. Both ports bypass independently, and the same address on both ports is legal.
- wr_onehot_q <= strobe every cycle (not held). It holds 0 on any cycle after a cycle without a write.
- Scoreboard, per bit n each rising edge (not in reset):
  - set_n = busy_set & busy_addr==n.
  - clr_n = wr_en & wr_addr==n.
  - busy[n] <= set_n ? 1 : (clr_n ? 0 : busy[n]).
  - Simultaneous set and clear on the same n: set wins, because a new producer was issued.
  - Clearing a non-busy register is a no-op.
  - Setting an already-busy register keeps it busy; there is no counting.
- Hazards: hazardN = busy[rd_addrN] & ~(wr_en & wr_addr==rd_addrN). A same-cycle writeback satisfies the read through the bypass. busy_set in the current cycle does not affect hazardN until the next cycle.
- No register is hardwired to zero; all 8 are writable.
- Reset mid-operation: outstanding busy bits are discarded, and data written in the reset cycle is lost.

Test Plan:
- Reset with random prior contents, then read all 8 addresses on both ports -> every read returns 0x00000000; busy=0x00; wr_onehot_q=0x00.
- Write wr_addr=5, wr_data=0xDEADBEEF; next cycle read rd_addr1=5 -> rd_data1=0xDEADBEEF, wr_onehot_q=0x20 for exactly one cycle, then 0x00.
- Bypass: wr_en=1, wr_addr=3, wr_data=0x12345678, rd_addr1=rd_addr2=3 in the same cycle -> both rd_data=0x12345678 combinationally, before the edge.
- Scoreboard: busy_set addr 2 -> next cycle busy=0x04 and hazard1=1 with rd_addr1=2. Writeback addr 2 that cycle -> hazard1=0 same cycle. Next cycle busy=0x00.
- Simultaneous busy_set and wr_en both to addr 6 while busy[6]=1 -> busy[6] remains 1.
- Assert reset while busy=0xFF and wr_en=1, addr 1, data 0xAA -> next cycle busy=0x00, reg1 reads 0, wr_onehot_q=0x00.

Source files
------------

// File: rtl/regfile_8x32_sb.sv
// Eight-entry register file: two combinational read ports with write-through bypass,
// one synchronous write port, a per-register busy scoreboard and a registered write one-hot.
module regfile_8x32_sb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    output logic             hazard1,
    input  logic [2:0]       rd_addr2,
    output logic [WIDTH-1:0] rd_data2,
    output logic             hazard2,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             busy_set,
    input  logic [2:0]       busy_addr,
    output logic [NREG-1:0]  busy,
    output logic [NREG-1:0]  wr_onehot_q
);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [NREG-1:0]  wr_strobe;
    logic [NREG-1:0]  set_vec;
    logic             byp1;
    logic             byp2;

    always_comb begin
        wr_strobe = '0;
        if (wr_en) begin
            wr_strobe[wr_addr] = 1'b1;
        end
    end

    always_comb begin
        set_vec = '0;
        if (busy_set) begin
            set_vec[busy_addr] = 1'b1;
        end
    end

    // Set is ORed in after the clear so a newly issued producer wins over a retiring one.
    always_comb begin
        busy_d = (busy_q & ~wr_strobe) | set_vec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q      <= '0;
            wr_onehot_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (wr_strobe[i]) begin
                    regs_q[i] <= wr_data;
                end
            end
            busy_q      <= busy_d;
            wr_onehot_q <= wr_strobe;
        end
    end

    always_comb begin
        byp1     = wr_en && (wr_addr == rd_addr1);
        byp2     = wr_en && (wr_addr == rd_addr2);
        rd_data1 = byp1 ? wr_data : regs_q[rd_addr1];
        rd_data2 = byp2 ? wr_data : regs_q[rd_addr2];
        hazard1  = busy_q[rd_addr1] & ~byp1;
        hazard2  = busy_q[rd_addr2] & ~byp2;
        busy     = busy_q;
    end

endmodule

// File: tb/tb_regfile_8x32_sb.sv
// Directed bench for regfile_8x32_sb: reset, write latency, bypass, scoreboard set/clear
// priority and reset during activity, with hand-computed expectations.
module tb_regfile_8x32_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic        hazard1;
    logic [2:0]  rd_addr2;
    logic [31:0] rd_data2;
    logic        hazard2;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy_set;
    logic [2:0]  busy_addr;
    logic [7:0]  busy;
    logic [7:0]  wr_onehot_q;

    int unsigned checks = 0;
    int unsigned errors = 0;

    regfile_8x32_sb #(.WIDTH(32), .NREG(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr1   (rd_addr1),
        .rd_data1   (rd_data1),
        .hazard1    (hazard1),
        .rd_addr2   (rd_addr2),
        .rd_data2   (rd_data2),
        .hazard2    (hazard2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy_set   (busy_set),
        .busy_addr  (busy_addr),
        .busy       (busy),
        .wr_onehot_q(wr_onehot_q)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; rd_addr1 = '0; rd_addr2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        busy_set = 1'b0; busy_addr = '0;
        step();
        reset = 1'b0;

        // Fill with random contents and mark every register busy.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = $urandom | 32'h1;
            busy_set = 1'b1; busy_addr = 3'(i);
            step();
        end
        wr_en = 1'b0; busy_set = 1'b0;
        #1;
        chk("prefill_busy", {24'h0, busy}, 32'h0000_00FF);

        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = 3'(i); rd_addr2 = 3'(7 - i);
            #1;
            chk("rst_rd1", rd_data1, 32'h0);
            chk("rst_rd2", rd_data2, 32'h0);
            chk("rst_hz1", {31'h0, hazard1}, 32'h0);
            chk("rst_hz2", {31'h0, hazard2}, 32'h0);
        end
        chk("rst_busy", {24'h0, busy}, 32'h0);
        chk("rst_onehot", {24'h0, wr_onehot_q}, 32'h0);

        // Write latency and one-cycle one-hot pulse.
        rd_addr1 = 3'd0;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'hDEAD_BEEF;
        step();
        wr_en = 1'b0; rd_addr1 = 3'd5;
        #1;
        chk("wr5_rd1", rd_data1, 32'hDEAD_BEEF);
        chk("wr5_onehot", {24'h0, wr_onehot_q}, 32'h0000_0020);
        step();
        chk("wr5_onehot_clr", {24'h0, wr_onehot_q}, 32'h0);
        chk("wr5_hold", rd_data1, 32'hDEAD_BEEF);

        // Same-cycle bypass on both ports before the edge.
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h1234_5678;
        rd_addr1 = 3'd3; rd_addr2 = 3'd3;
        #1;
        chk("byp_rd1", rd_data1, 32'h1234_5678);
        chk("byp_rd2", rd_data2, 32'h1234_5678);
        chk("byp_onehot_pre", {24'h0, wr_onehot_q}, 32'h0);
        step();
        wr_en = 1'b0;
        #1;
        chk("byp_array", rd_data1, 32'h1234_5678);
        chk("byp_onehot", {24'h0, wr_onehot_q}, 32'h0000_0008);

        // Scoreboard set, hazard, writeback clear.
        busy_set = 1'b1; busy_addr = 3'd2; rd_addr1 = 3'd2; rd_addr2 = 3'd4;
        #1;
        chk("sb_set_nohz", {31'h0, hazard1}, 32'h0);
        step();
        busy_set = 1'b0;
        #1;
        chk("sb_busy2", {24'h0, busy}, 32'h0000_0004);
        chk("sb_hz1", {31'h0, hazard1}, 32'h1);
        chk("sb_hz2", {31'h0, hazard2}, 32'h0);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h0000_0001;
        #1;
        chk("sb_hz_other_wr", {31'h0, hazard1}, 32'h1);
        wr_addr = 3'd2; wr_data = 32'hCAFE_F00D;
        #1;
        chk("sb_hz_wb", {31'h0, hazard1}, 32'h0);
        chk("sb_wb_byp", rd_data1, 32'hCAFE_F00D);
        step();
        wr_en = 1'b0;
        #1;
        chk("sb_clr", {24'h0, busy}, 32'h0);
        chk("sb_clr_hz", {31'h0, hazard1}, 32'h0);
        chk("sb_rd", rd_data1, 32'hCAFE_F00D);

        // Set wins over simultaneous clear.
        busy_set = 1'b1; busy_addr = 3'd6;
        step();
        busy_set = 1'b0; rd_addr1 = 3'd6; rd_addr2 = 3'd6;
        #1;
        chk("sb_busy6", {24'h0, busy}, 32'h0000_0040);
        chk("sb6_hz1", {31'h0, hazard1}, 32'h1);
        busy_set = 1'b1; busy_addr = 3'd6;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'h0000_0066;
        #1;
        chk("sb6_hz2_wb", {31'h0, hazard2}, 32'h0);
        step();
        busy_set = 1'b0; wr_en = 1'b0;
        #1;
        chk("sb_setwins", {24'h0, busy}, 32'h0000_0040);
        chk("sb6_rd2", rd_data2, 32'h0000_0066);
        chk("sb6_hz2", {31'h0, hazard2}, 32'h1);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h0000_0A0A;
        step();
        wr_en = 1'b0;
        #1;
        chk("sb_clr_nonbusy", {24'h0, busy}, 32'h0000_0040);
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'h0000_0067;
        step();
        wr_en = 1'b0;
        #1;
        chk("sb_clr6", {24'h0, busy}, 32'h0);

        // Reset during activity discards busy bits and the in-flight write.
        for (int i = 0; i < 8; i++) begin
            busy_set = 1'b1; busy_addr = 3'(i);
            step();
        end
        busy_set = 1'b0;
        #1;
        chk("mid_busy_ff", {24'h0, busy}, 32'h0000_00FF);
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h0000_00AA;
        busy_set = 1'b1; busy_addr = 3'd3;
        step();
        reset = 1'b0; wr_en = 1'b0; busy_set = 1'b0;
        rd_addr1 = 3'd1; rd_addr2 = 3'd3;
        #1;
        chk("mid_busy", {24'h0, busy}, 32'h0);
        chk("mid_rd1", rd_data1, 32'h0);
        chk("mid_rd2", rd_data2, 32'h0);
        chk("mid_onehot", {24'h0, wr_onehot_q}, 32'h0);
        chk("mid_hz1", {31'h0, hazard1}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
